// File: rtl/pic_pkg.sv
// 8259A host command decoder: shared state encoding and bit positions.
package pic_pkg;

  typedef enum logic [2:0] {
    UNINIT,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } pic_state_e;

  localparam int ICW1_IDX = 0;
  localparam int ICW2_IDX = 1;
  localparam int ICW3_IDX = 2;
  localparam int ICW4_IDX = 3;

  localparam int OCW1_IDX = 0;
  localparam int OCW2_IDX = 1;
  localparam int OCW3_IDX = 2;

  localparam int ICW1_BIT_D4 = 4;
  localparam int OCW3_BIT_D3 = 3;

endpackage

// File: rtl/pic_strobe_sync.sv
// Multi-flop synchroniser for one asynchronous bus strobe,
// with the previous synced sample and rise/fall detect.
module pic_strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic prev,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;

  // Reset to 0 so a strobe held low across reset never looks like a fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/pic_rw_cmd_sequencer.sv
// 8259A read/write command decoder: syncs the host bus, tracks the
// ICW1..ICW4 init sequence and strobes ICW/OCW flags.
module pic_rw_cmd_sequencer
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CS_n,
  input  logic              WR_n,
  input  logic              RD_n,
  input  logic              A0,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic [3:0]        ICWs_Flags,
  output logic [2:0]        OCWs_Flags,
  output logic              init_done,
  output logic              rd_en,
  output logic              rd_a0
);

  logic wr_s, wr_p, wr_rise, wr_fall;
  logic cs_s, cs_p, cs_rise, cs_fall;
  logic rd_s, rd_p, rd_rise, rd_fall;

  pic_strobe_sync #(.STAGES(SYNC_STAGES)) u_wr (
    .clk(clk), .rst_n(rst_n), .async_in(WR_n),
    .level(wr_s), .prev(wr_p), .rise(wr_rise), .fall(wr_fall)
  );

  pic_strobe_sync #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(clk), .rst_n(rst_n), .async_in(CS_n),
    .level(cs_s), .prev(cs_p), .rise(cs_rise), .fall(cs_fall)
  );

  pic_strobe_sync #(.STAGES(SYNC_STAGES)) u_rd (
    .clk(clk), .rst_n(rst_n), .async_in(RD_n),
    .level(rd_s), .prev(rd_p), .rise(rd_rise), .fall(rd_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{wr_p, cs_fall, rd_p, rd_rise, rd_fall};

  logic              sh_a0;
  logic [DATA_W-1:0] sh_d;
  logic              armed;
  logic              wr_ev;

  // A write counts only if its falling edge was seen while selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a0 <= 1'b0;
      sh_d  <= '0;
      armed <= 1'b0;
    end else begin
      if (!wr_s && !cs_s) begin
        sh_a0 <= A0;
        sh_d  <= D;
      end
      if (wr_fall && !cs_s)
        armed <= 1'b1;
      else if (wr_rise || cs_rise)
        armed <= 1'b0;
    end
  end

  assign wr_ev = wr_rise & ~cs_p & armed;

  pic_state_e state;
  logic       sngl;
  logic       ic4;
  logic       is_icw1;
  logic       is_ocw2;
  logic       is_ocw3;
  logic       rd_next;

  assign is_icw1 = ~sh_a0 & sh_d[ICW1_BIT_D4];
  assign is_ocw2 = ~sh_a0 & ~sh_d[ICW1_BIT_D4] & ~sh_d[OCW3_BIT_D3];
  assign is_ocw3 = ~sh_a0 & ~sh_d[ICW1_BIT_D4] & sh_d[OCW3_BIT_D3];
  assign rd_next = ~rd_s & ~cs_s & wr_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= UNINIT;
      sngl       <= 1'b0;
      ic4        <= 1'b0;
      ICWs_Flags <= '0;
      OCWs_Flags <= '0;
      DATA_OUT   <= '0;
      init_done  <= 1'b0;
      rd_en      <= 1'b0;
      rd_a0      <= 1'b0;
    end else begin
      ICWs_Flags <= '0;
      OCWs_Flags <= '0;
      init_done  <= (state == READY);
      rd_en      <= rd_next;
      if (rd_next && !rd_en)
        rd_a0 <= A0;
      if (wr_ev) begin
        unique case (1'b1)
          is_icw1: begin
            sngl                 <= sh_d[1];
            ic4                  <= sh_d[0];
            ICWs_Flags[ICW1_IDX] <= 1'b1;
            DATA_OUT             <= sh_d;
            init_done            <= 1'b0;
            state                <= WAIT_ICW2;
          end
          (state == WAIT_ICW2) && sh_a0: begin
            ICWs_Flags[ICW2_IDX] <= 1'b1;
            DATA_OUT             <= sh_d;
            state <= !sngl ? WAIT_ICW3 : (ic4 ? WAIT_ICW4 : READY);
          end
          (state == WAIT_ICW3) && sh_a0: begin
            ICWs_Flags[ICW3_IDX] <= 1'b1;
            DATA_OUT             <= sh_d;
            state                <= ic4 ? WAIT_ICW4 : READY;
          end
          (state == WAIT_ICW4) && sh_a0: begin
            ICWs_Flags[ICW4_IDX] <= 1'b1;
            DATA_OUT             <= sh_d;
            state                <= READY;
          end
          (state == READY) && sh_a0: begin
            OCWs_Flags[OCW1_IDX] <= 1'b1;
            DATA_OUT             <= sh_d;
          end
          (state == READY) && is_ocw2: begin
            OCWs_Flags[OCW2_IDX] <= 1'b1;
            DATA_OUT             <= sh_d;
          end
          (state == READY) && is_ocw3: begin
            OCWs_Flags[OCW3_IDX] <= 1'b1;
            DATA_OUT             <= sh_d;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
